// File: rtl/id_ex_pipe_if.sv
// ID/EX stage bus: forwarded ID operands in, EX-stage register contents and
// stall/performance signals out.
interface id_ex_pipe_if #(
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [31:0]       id_pc;
    logic [4:0]        id_rd_A;
    logic [4:0]        id_rd_B;
    logic              id_uses_B;
    logic [4:0]        id_dst;
    logic [31:0]       id_rdata_A_sel;
    logic [31:0]       id_rdata_B_sel;
    logic [31:0]       id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_is_load;
    logic              ex_ready;
    logic              ex_flush;

    logic              ie_valid;
    logic [31:0]       ie_pc;
    logic [4:0]        IE_rd;
    logic [31:0]       ie_rdata_A;
    logic [31:0]       ie_rdata_B;
    logic [31:0]       ie_imm;
    logic [CTRL_W-1:0] ie_ctrl;
    logic              ie_is_load;
    logic              id_stall;
    logic [CNT_W-1:0]  bubble_cnt;
    logic [CNT_W-1:0]  hold_cnt;

    modport master (
        output id_valid, id_pc, id_rd_A, id_rd_B, id_uses_B, id_dst,
               id_rdata_A_sel, id_rdata_B_sel, id_imm, id_ctrl, id_is_load,
               ex_ready, ex_flush,
        input  ie_valid, ie_pc, IE_rd, ie_rdata_A, ie_rdata_B, ie_imm,
               ie_ctrl, ie_is_load, id_stall, bubble_cnt, hold_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_rd_A, id_rd_B, id_uses_B, id_dst,
               id_rdata_A_sel, id_rdata_B_sel, id_imm, id_ctrl, id_is_load,
               ex_ready, ex_flush,
        output ie_valid, ie_pc, IE_rd, ie_rdata_A, ie_rdata_B, ie_imm,
               ie_ctrl, ie_is_load, id_stall, bubble_cnt, hold_cnt
    );
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion, EX back-pressure
// hold and branch flush, plus saturating bubble/hold counters.
module id_ex_pipe #(
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_pipe_if.slave  bus
);
    typedef enum logic {RUN, HOLD} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_valid;
    logic [31:0]       r_pc;
    logic [4:0]        r_rd;
    logic [31:0]       r_a;
    logic [31:0]       r_b;
    logic [31:0]       r_imm;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_load;
    logic [CNT_W-1:0]  r_bub_cnt;
    logic [CNT_W-1:0]  r_hold_cnt;

    logic w_lu_haz;
    logic w_bubble;
    logic w_capture;
    logic w_stall;
    logic w_hold_inc;
    logic w_bub_inc;

    // A load only hazards on a real destination; r0 is never written.
    assign w_lu_haz = r_valid && r_load && (r_rd != 5'd0) && bus.id_valid &&
                      ((bus.id_rd_A == r_rd) ||
                       (bus.id_uses_B && (bus.id_rd_B == r_rd)));

    always_comb begin
        w_next     = r_state;
        w_bubble   = 1'b0;
        w_capture  = 1'b0;
        w_stall    = 1'b0;
        w_hold_inc = 1'b0;
        w_bub_inc  = 1'b0;
        case (r_state)
            RUN: begin
                if (bus.ex_flush) begin
                    w_bubble = 1'b1;
                end else if (!bus.ex_ready) begin
                    w_stall    = 1'b1;
                    w_hold_inc = 1'b1;
                    w_next     = HOLD;
                end else if (w_lu_haz) begin
                    w_bubble  = 1'b1;
                    w_stall   = 1'b1;
                    w_bub_inc = 1'b1;
                end else begin
                    w_capture = 1'b1;
                end
            end
            HOLD: begin
                if (bus.ex_flush) begin
                    w_bubble = 1'b1;
                    w_next   = RUN;
                end else if (!bus.ex_ready) begin
                    w_stall    = 1'b1;
                    w_hold_inc = 1'b1;
                end else begin
                    // Leaving HOLD acts as RUN this same cycle so no slot is lost.
                    w_next = RUN;
                    if (w_lu_haz) begin
                        w_bubble  = 1'b1;
                        w_stall   = 1'b1;
                        w_bub_inc = 1'b1;
                    end else begin
                        w_capture = 1'b1;
                    end
                end
            end
            default: w_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rd       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_imm      <= '0;
            r_ctrl     <= '0;
            r_load     <= 1'b0;
            r_bub_cnt  <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_bubble) begin
                r_valid <= 1'b0;
                r_pc    <= '0;
                r_rd    <= '0;
                r_a     <= '0;
                r_b     <= '0;
                r_imm   <= '0;
                r_ctrl  <= '0;
                r_load  <= 1'b0;
            end else if (w_capture) begin
                r_valid <= bus.id_valid;
                r_pc    <= bus.id_pc;
                r_rd    <= bus.id_valid ? bus.id_dst : 5'd0;
                r_a     <= bus.id_rdata_A_sel;
                r_b     <= bus.id_rdata_B_sel;
                r_imm   <= bus.id_imm;
                r_ctrl  <= bus.id_ctrl;
                r_load  <= bus.id_is_load;
            end
            if (w_bub_inc && (r_bub_cnt != '1))
                r_bub_cnt <= r_bub_cnt + CNT_W'(1);
            if (w_hold_inc && (r_hold_cnt != '1))
                r_hold_cnt <= r_hold_cnt + CNT_W'(1);
        end
    end

    assign bus.ie_valid   = r_valid;
    assign bus.ie_pc      = r_pc;
    assign bus.IE_rd      = r_rd;
    assign bus.ie_rdata_A = r_a;
    assign bus.ie_rdata_B = r_b;
    assign bus.ie_imm     = r_imm;
    assign bus.ie_ctrl    = r_ctrl;
    assign bus.ie_is_load = r_load;
    assign bus.id_stall   = w_stall;
    assign bus.bubble_cnt = r_bub_cnt;
    assign bus.hold_cnt   = r_hold_cnt;
endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed hazard/hold/flush scenarios
// followed by random traffic, all checked against a behavioural model.
module tb_id_ex_pipe;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 2;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    id_ex_pipe_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

    id_ex_pipe #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int testsRun    = 0;
    int testsFailed = 0;
    bit checkEn     = 1'b0;

    logic              mValid;
    logic [31:0]       mPc;
    logic [4:0]        mRd;
    logic [31:0]       mA;
    logic [31:0]       mB;
    logic [31:0]       mImm;
    logic [CTRL_W-1:0] mCtrl;
    logic              mLoad;
    int                mBub;
    int                mHold;

    // The ID instruction must wait when it reads the register a load in EX is still fetching.
    function automatic bit modelHaz();
        return mValid && mLoad && (mRd != 0) && bus.id_valid &&
               ((bus.id_rd_A == mRd) || (bus.id_uses_B && (bus.id_rd_B == mRd)));
    endfunction

    function automatic bit modelStall();
        return !bus.ex_flush && (!bus.ex_ready || modelHaz());
    endfunction

    // Reference model of the EX-side register contents, one update per clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || bus.ex_flush || (bus.ex_ready && modelHaz())) begin
            mValid <= 1'b0;
            mPc    <= '0;
            mRd    <= '0;
            mA     <= '0;
            mB     <= '0;
            mImm   <= '0;
            mCtrl  <= '0;
            mLoad  <= 1'b0;
            if (!rst_n) begin
                mBub  <= 0;
                mHold <= 0;
            end else if (!bus.ex_flush) begin
                mBub <= (mBub < MAXC) ? mBub + 1 : MAXC;
            end
        end else if (!bus.ex_ready) begin
            mHold <= (mHold < MAXC) ? mHold + 1 : MAXC;
        end else begin
            mValid <= bus.id_valid;
            mPc    <= bus.id_pc;
            mRd    <= bus.id_valid ? bus.id_dst : 5'd0;
            mA     <= bus.id_rdata_A_sel;
            mB     <= bus.id_rdata_B_sel;
            mImm   <= bus.id_imm;
            mCtrl  <= bus.id_ctrl;
            mLoad  <= bus.id_is_load;
        end
    end

    task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, the DUT outputs must agree with the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("ie_bundle",
                {bus.ie_valid, bus.ie_pc, bus.IE_rd, bus.ie_rdata_A, bus.ie_rdata_B,
                 bus.ie_imm, bus.ie_ctrl, bus.ie_is_load},
                {mValid, mPc, mRd, mA, mB, mImm, mCtrl, mLoad});
            checkOutput("id_stall", 160'(bus.id_stall), 160'(modelStall()));
            checkOutput("bubble_cnt", 160'(bus.bubble_cnt), 160'(mBub));
            checkOutput("hold_cnt", 160'(bus.hold_cnt), 160'(mHold));
        end
    end

    task automatic applyStimulus(input logic v, input logic [4:0] rdA, input logic [4:0] rdB,
                                 input logic usesB, input logic [4:0] dst, input logic ld,
                                 input logic rdy, input logic fl);
        bus.id_valid       = v;
        bus.id_pc          = $urandom;
        bus.id_rd_A        = rdA;
        bus.id_rd_B        = rdB;
        bus.id_uses_B      = usesB;
        bus.id_dst         = dst;
        bus.id_rdata_A_sel = $urandom;
        bus.id_rdata_B_sel = $urandom;
        bus.id_imm         = $urandom;
        bus.id_ctrl        = CTRL_W'($urandom);
        bus.id_is_load     = ld;
        bus.ex_ready       = rdy;
        bus.ex_flush       = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic stallCheck(input string name, input logic exp);
        @(negedge clk);
        checkOutput(name, 160'(bus.id_stall), 160'(exp));
    endtask

    initial begin
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        #1 rst_n = 1'b0;
        checkEn = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1, 5'(i + 10), 0, 1, 5'(i), 0, 1, 0);
            stallCheck("stream_stall", 1'b0);
            tick();
            checkOutput("stream_IE_rd", 160'(bus.IE_rd), 160'(i));
        end

        applyStimulus(1, 0, 0, 0, 5, 1, 1, 0);
        tick();
        applyStimulus(1, 5, 0, 0, 6, 0, 1, 0);
        stallCheck("lu_stall", 1'b1);
        tick();
        checkOutput("lu_bubble", 160'({bus.ie_valid, bus.IE_rd}), 160'(0));
        checkOutput("lu_bubble_cnt", 160'(bus.bubble_cnt), 160'(1));
        stallCheck("lu_release", 1'b0);
        tick();
        checkOutput("lu_capture", 160'(bus.IE_rd), 160'(6));

        applyStimulus(1, 0, 0, 0, 5, 1, 1, 0);
        tick();
        applyStimulus(1, 1, 5, 0, 7, 0, 1, 0);
        stallCheck("immB_stall", 1'b0);
        tick();
        checkOutput("immB_capture", 160'(bus.IE_rd), 160'(7));
        checkOutput("immB_bubble_cnt", 160'(bus.bubble_cnt), 160'(1));

        applyStimulus(1, 0, 0, 0, 0, 1, 1, 0);
        tick();
        applyStimulus(1, 0, 0, 1, 8, 0, 1, 0);
        stallCheck("r0_stall", 1'b0);
        tick();
        checkOutput("r0_capture", 160'({bus.ie_valid, bus.IE_rd}), 160'({1'b1, 5'd8}));

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 0, 9, 0, 0, 0);
            stallCheck("bp_stall", 1'b1);
            tick();
            checkOutput("bp_hold_rd", 160'(bus.IE_rd), 160'(8));
        end
        checkOutput("bp_hold_cnt", 160'(bus.hold_cnt), 160'(3));
        applyStimulus(1, 0, 0, 0, 9, 0, 1, 0);
        stallCheck("bp_ready_stall", 1'b0);
        tick();
        checkOutput("bp_capture", 160'(bus.IE_rd), 160'(9));

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, 0, 12, 0, 0, 0);
            tick();
        end
        checkOutput("hold_cnt_sat", 160'(bus.hold_cnt), 160'(3));

        applyStimulus(1, 0, 0, 0, 5, 1, 1, 0);
        tick();
        applyStimulus(1, 5, 0, 0, 6, 0, 1, 1);
        stallCheck("flush_lu_stall", 1'b0);
        tick();
        checkOutput("flush_lu_bubble", 160'({bus.ie_valid, bus.IE_rd}), 160'(0));
        checkOutput("flush_lu_bubble_cnt", 160'(bus.bubble_cnt), 160'(1));

        applyStimulus(1, 0, 0, 0, 10, 0, 1, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 11, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 11, 0, 0, 1);
        stallCheck("flush_hold_stall", 1'b0);
        tick();
        checkOutput("flush_hold_bubble", 160'({bus.ie_valid, bus.IE_rd}), 160'(0));
        applyStimulus(1, 0, 0, 0, 11, 0, 1, 0);
        stallCheck("after_flush_stall", 1'b0);
        tick();
        checkOutput("after_flush_capture", 160'(bus.IE_rd), 160'(11));

        applyStimulus(1, 0, 0, 0, 7, 0, 1, 0);
        tick();
        checkOutput("pre_reset_rd", 160'({bus.ie_valid, bus.IE_rd}), 160'({1'b1, 5'd7}));
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 160'({bus.ie_valid, bus.IE_rd, bus.bubble_cnt}), 160'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          1'($urandom), 5'($urandom_range(0, 3)),
                          ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
            if (i == 1500) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            tick();
        end

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        repeat (2) tick();
        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
